// File: rtl/tdm_slot_if.sv
// tdm_slot_if: phase/data inputs and frame handshake outputs of the TDM slot sampler
interface tdm_slot_if #(parameter int N = 4, parameter int W = 8, parameter int CW = 8);
  logic [N-1:0] phase;
  logic [W-1:0] data_in;
  logic frame_ready;
  logic frame_valid;
  logic [N*W-1:0] frame_data;
  logic phase_err;
  logic overflow;
  logic [CW-1:0] frame_cnt;
  modport master(output phase, data_in, frame_ready, input frame_valid, frame_data, phase_err, overflow, frame_cnt);
  modport slave(input phase, data_in, frame_ready, output frame_valid, frame_data, phase_err, overflow, frame_cnt);
endinterface

// File: rtl/tdm_slot_sampler.sv
// tdm_slot_sampler: captures one word per one-hot phase slot, emits N-slot frames over valid/ready
module tdm_slot_sampler #(parameter int N = 4, parameter int W = 8, parameter int CW = 8) (
  input logic clk,
  input logic reset,
  tdm_slot_if.slave bus
);
  typedef enum logic {HUNT, COLLECT} state_t;
  state_t state, state_n;
  logic [N-1:0] mask, mask_n;
  logic [N-1:0][W-1:0] slot, slot_n, frame_q, frame_n;
  logic valid_q, valid_n, err_q, err_n, ovf_q, ovf_n;
  logic [CW-1:0] cnt_q;
  logic onehot, capture, complete, accept;
  assign onehot = $onehot(bus.phase);
  assign accept = valid_q & bus.frame_ready;
  assign capture = onehot && (state == COLLECT || bus.phase[0]);
  always_comb begin
    state_n = state;
    mask_n = mask;
    slot_n = slot;
    frame_n = frame_q;
    valid_n = accept ? 1'b0 : valid_q;
    err_n = 1'b0;
    ovf_n = 1'b0;
    complete = 1'b0;
    if (!onehot) begin
      err_n = 1'b1;
      mask_n = '0;
      state_n = HUNT;
    end else if (capture) begin
      for (int i = 0; i < N; i++) if (bus.phase[i]) slot_n[i] = bus.data_in;
      complete = bus.phase[1] && &(mask | bus.phase);
      mask_n = complete ? '0 : bus.phase[0] ? bus.phase : mask | bus.phase;
      state_n = COLLECT;
    end
    if (complete && valid_q && !bus.frame_ready) ovf_n = 1'b1;
    else if (complete) begin
      frame_n = slot_n;
      valid_n = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= HUNT;
      mask <= '0;
      slot <= '0;
      frame_q <= '0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state <= state_n;
      mask <= mask_n;
      slot <= slot_n;
      frame_q <= frame_n;
      valid_q <= valid_n;
      err_q <= err_n;
      ovf_q <= ovf_n;
      cnt_q <= cnt_q + CW'(accept);
    end
  end
  assign bus.frame_valid = valid_q;
  assign bus.frame_data = frame_q;
  assign bus.phase_err = err_q;
  assign bus.overflow = ovf_q;
  assign bus.frame_cnt = cnt_q;
endmodule

// File: tb/tb_tdm_slot_sampler.sv
// tb_tdm_slot_sampler: directed ring passes with a frame scoreboard popped on each accept
module tb_tdm_slot_sampler;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  int ovf_seen = 0;
  int err_seen = 0;
  logic [31:0] exp_q[$];
  tdm_slot_if bus();
  tdm_slot_sampler dut(.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (reset && bus.overflow) ovf_seen++;
    if (reset && bus.phase_err) err_seen++;
    if (reset && bus.frame_valid && bus.frame_ready) begin
      if (exp_q.size() == 0) chk("queue_underflow", 64'(exp_q.size()), 64'd1);
      else chk("frame_data", 64'(bus.frame_data), 64'(exp_q.pop_front()));
    end
  end
  task automatic drive(input logic [3:0] ph, input logic [7:0] d);
    bus.phase = ph;
    bus.data_in = d;
    @(posedge clk);
    #1;
  endtask
  task automatic ring(input logic [7:0] d0, d3, d2, d1, input bit push);
    if (push) exp_q.push_back({d3, d2, d1, d0});
    drive(4'b0001, d0);
    drive(4'b1000, d3);
    drive(4'b0100, d2);
    drive(4'b0010, d1);
  endtask
  task automatic zeros(input string tag);
    chk({tag, "_valid"}, 64'(bus.frame_valid), 64'd0);
    chk({tag, "_data"}, 64'(bus.frame_data), 64'd0);
    chk({tag, "_err"}, 64'(bus.phase_err), 64'd0);
    chk({tag, "_ovf"}, 64'(bus.overflow), 64'd0);
    chk({tag, "_cnt"}, 64'(bus.frame_cnt), 64'd0);
  endtask
  initial begin
    int ovf0, err0;
    bus.phase = 4'b0001;
    bus.data_in = '0;
    bus.frame_ready = 1'b1;
    drive(4'b0001, 8'h00);
    drive(4'b0001, 8'h00);
    zeros("reset");
    reset = 1'b1;
    ring(8'h11, 8'h44, 8'h33, 8'h22, 1);
    chk("t1_valid", 64'(bus.frame_valid), 64'd1);
    chk("t1_data", 64'(bus.frame_data), 64'h44332211);
    drive(4'b0001, 8'h00);
    chk("t1_cnt", 64'(bus.frame_cnt), 64'd1);
    chk("t1_valid_drop", 64'(bus.frame_valid), 64'd0);
    reset = 1'b0;
    drive(4'b0001, 8'h00);
    reset = 1'b1;
    drive(4'b0100, 8'hee);
    drive(4'b0010, 8'hee);
    chk("t2_hunt_valid", 64'(bus.frame_valid), 64'd0);
    ring(8'ha5, 8'hb6, 8'hc7, 8'hd8, 1);
    chk("t2_data", 64'(bus.frame_data), 64'hb6c7d8a5);
    drive(4'b0001, 8'h00);
    chk("t2_cnt", 64'(bus.frame_cnt), 64'd1);
    bus.frame_ready = 1'b0;
    ovf0 = ovf_seen;
    ring(8'h01, 8'h04, 8'h03, 8'h02, 1);
    chk("t3_ovf_first", 64'(bus.overflow), 64'd0);
    ring(8'h55, 8'h66, 8'h77, 8'h88, 0);
    chk("t3_ovf_pulse", 64'(bus.overflow), 64'd1);
    chk("t3_held", 64'(bus.frame_data), 64'h04030201);
    drive(4'b0001, 8'h00);
    chk("t3_ovf_clear", 64'(bus.overflow), 64'd0);
    chk("t3_cnt_hold", 64'(bus.frame_cnt), 64'd1);
    chk("t3_ovf_count", 64'(ovf_seen - ovf0), 64'd1);
    bus.frame_ready = 1'b1;
    drive(4'b0001, 8'h00);
    chk("t3_cnt", 64'(bus.frame_cnt), 64'd2);
    chk("t3_valid_drop", 64'(bus.frame_valid), 64'd0);
    drive(4'b0001, 8'h10);
    drive(4'b1000, 8'h13);
    drive(4'b0110, 8'hff);
    chk("t4_err_pulse", 64'(bus.phase_err), 64'd1);
    drive(4'b0100, 8'h12);
    chk("t4_err_clear", 64'(bus.phase_err), 64'd0);
    drive(4'b0010, 8'h11);
    chk("t4_no_frame", 64'(bus.frame_valid), 64'd0);
    ring(8'h20, 8'h23, 8'h22, 8'h21, 1);
    chk("t4_data", 64'(bus.frame_data), 64'h23222120);
    drive(4'b0001, 8'h00);
    chk("t4_cnt", 64'(bus.frame_cnt), 64'd3);
    bus.frame_ready = 1'b0;
    ring(8'h30, 8'h33, 8'h32, 8'h31, 0);
    chk("t5_valid", 64'(bus.frame_valid), 64'd1);
    reset = 1'b0;
    drive(4'b0001, 8'h00);
    zeros("t5_reset");
    reset = 1'b1;
    drive(4'b1000, 8'h9);
    drive(4'b0100, 8'h9);
    drive(4'b0010, 8'h9);
    chk("t5_hunt_valid", 64'(bus.frame_valid), 64'd0);
    bus.frame_ready = 1'b1;
    ring(8'h40, 8'h43, 8'h42, 8'h41, 1);
    chk("t5_data", 64'(bus.frame_data), 64'h43424140);
    drive(4'b0001, 8'h00);
    chk("t5_cnt", 64'(bus.frame_cnt), 64'd1);
    ovf0 = ovf_seen;
    err0 = err_seen;
    for (int i = 0; i < 300; i++) begin
      ring(8'(i), 8'(i + 3), 8'(i + 2), 8'(i + 1), 1);
      chk("t6_cnt", 64'(bus.frame_cnt), 64'((1 + i) % 256));
    end
    drive(4'b0001, 8'h00);
    chk("t6_cnt_wrap", 64'(bus.frame_cnt), 64'd45);
    chk("t6_no_ovf", 64'(ovf_seen - ovf0), 64'd0);
    chk("t6_no_err", 64'(err_seen - err0), 64'd0);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
